// File: rtl/dcache_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// dcache_pkg : shared state type and geometry helpers for the data cache. Rev 1.0
//------------------------------------------------------------------------------
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    FLUSH  = 2'd2
  } dc_state_t;

  localparam int OFFSET_W = 4;

  function automatic int tag_width(input int sets);
    return 32 - OFFSET_W - $clog2(sets);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_line_store.sv
`default_nettype none
//------------------------------------------------------------------------------
// dcache_line_store : valid/tag/data arrays, combinational read, sync writes. Rev 1.0
//------------------------------------------------------------------------------
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 16,
  parameter int IW         = 4,
  parameter int TW         = 24
) (
  input  logic                        clk,
  input  logic                        clr_all,
  input  logic [IW-1:0]               rd_idx,
  output logic                        rd_valid,
  output logic [TW-1:0]               rd_tag,
  output logic [3:0][DATA_WIDTH-1:0]  rd_line,
  input  logic                        fill_en,
  input  logic [TW-1:0]               fill_tag,
  input  logic [3:0][DATA_WIDTH-1:0]  fill_line,
  input  logic                        wr_en,
  input  logic                        wr_byte,
  input  logic [1:0]                  wr_word,
  input  logic [1:0]                  wr_lane,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        inv_en,
  input  logic [IW-1:0]               inv_idx
);

  logic [SETS-1:0]              valid_q, valid_d;
  logic [TW-1:0]                tag_q  [SETS];
  logic [TW-1:0]                tag_d  [SETS];
  logic [3:0][DATA_WIDTH-1:0]   data_q [SETS];
  logic [3:0][DATA_WIDTH-1:0]   data_d [SETS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

  // Fill and word/byte writes always target the line addressed by rd_idx.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d[rd_idx] = 1'b1;
      tag_d[rd_idx]   = fill_tag;
      data_d[rd_idx]  = fill_line;
    end
    if (wr_en) begin
      if (wr_byte)
        data_d[rd_idx][wr_word][{wr_lane, 3'b000} +: 8] = wr_data[7:0];
      else
        data_d[rd_idx][wr_word] = wr_data;
    end
    if (inv_en)
      valid_d[inv_idx] = 1'b0;
    if (clr_all)
      valid_d = '0;
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    tag_q   <= tag_d;
    data_q  <= data_d;
  end

endmodule
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
//------------------------------------------------------------------------------
// dcache_controller : direct-mapped write-through no-write-allocate D-cache. Rev 1.0
//------------------------------------------------------------------------------
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 16,
  parameter int MEM_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic                  cpu_byte,
  input  logic [31:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wd,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] cpu_rd,
  output logic                  stall,
  output logic                  mem_ren,
  output logic                  mem_we,
  output logic                  mem_byte,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_d0,
  input  logic [DATA_WIDTH-1:0] mem_d1,
  input  logic [DATA_WIDTH-1:0] mem_d2,
  input  logic [DATA_WIDTH-1:0] mem_d3,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int TW = tag_width(SETS);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  dc_state_t                   state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [IW-1:0]               fidx_q, fidx_d;
  logic                        retry_q, retry_d;
  logic [15:0]                 hit_q, hit_d, miss_q, miss_d;

  logic [IW-1:0]               idx;
  logic [TW-1:0]               tag;
  logic                        line_valid, hit;
  logic [TW-1:0]               line_tag;
  logic [3:0][DATA_WIDTH-1:0]  line;
  logic [DATA_WIDTH-1:0]       word;
  logic                        fill_en, wr_en, inv_en;

  assign idx  = cpu_addr[OFFSET_W +: IW];
  assign tag  = cpu_addr[31 -: TW];
  assign hit  = line_valid && (line_tag == tag);
  assign word = line[cpu_addr[3:2]];

  assign cpu_rd     = cpu_byte ? {{(DATA_WIDTH-8){1'b0}}, word[{cpu_addr[1:0], 3'b000} +: 8]} : word;
  assign mem_addr   = cpu_addr;
  assign mem_wd     = cpu_wd;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  dcache_line_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .SETS       (SETS),
    .IW         (IW),
    .TW         (TW)
  ) u_store (
    .clk       (clk),
    .clr_all   (!rst_n),
    .rd_idx    (idx),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_line   (line),
    .fill_en   (fill_en),
    .fill_tag  (tag),
    .fill_line ({mem_d3, mem_d2, mem_d1, mem_d0}),
    .wr_en     (wr_en),
    .wr_byte   (cpu_byte),
    .wr_word   (cpu_addr[3:2]),
    .wr_lane   (cpu_addr[1:0]),
    .wr_data   (cpu_wd),
    .inv_en    (inv_en),
    .inv_idx   (fidx_q)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fidx_d   = fidx_q;
    retry_d  = 1'b0;
    hit_d    = hit_q;
    miss_d   = miss_q;
    stall    = 1'b0;
    mem_ren  = 1'b0;
    mem_we   = 1'b0;
    mem_byte = 1'b0;
    fill_en  = 1'b0;
    wr_en    = 1'b0;
    inv_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = FLUSH;
          fidx_d  = '0;
          stall   = 1'b1;
        end else if (cpu_req && cpu_we) begin
          mem_we   = 1'b1;
          mem_byte = cpu_byte;
          wr_en    = hit;
        end else if (cpu_req) begin
          if (hit) begin
            // The load replayed right after a refill is not a real hit.
            if (!retry_q && hit_q != 16'hFFFF)
              hit_d = hit_q + 16'd1;
          end else begin
            stall   = 1'b1;
            state_d = REFILL;
            cnt_d   = CW'(MEM_LAT - 1);
            if (miss_q != 16'hFFFF)
              miss_d = miss_q + 16'd1;
          end
        end
      end
      REFILL: begin
        stall   = 1'b1;
        mem_ren = 1'b1;
        if (cnt_q == '0) begin
          fill_en = 1'b1;
          retry_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FLUSH: begin
        stall  = 1'b1;
        inv_en = 1'b1;
        if (fidx_q == IW'(SETS - 1))
          state_d = IDLE;
        else
          fidx_d = fidx_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fidx_q  <= '0;
      retry_q <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fidx_q  <= fidx_d;
      retry_q <= retry_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

endmodule
`default_nettype wire
